swd_frame_sequencer: RTL and testbench
======================================

Name: swd_frame_sequencer

Overview:
- Clocked host-side sequencer that sits directly upstream of swd_frontend_top and drives its sck/mosi/rst_n/rnw/output_enable_n inputs.
- Accepts one SWD transaction (request byte plus write data) per start pulse.
- Serialises the 48-bit frame at a programmable sck rate and captures the 3-bit ACK, plus read data and parity for reads, from the frontend's miso.
- Reports results through a done pulse.

Parameters:
- DIV, 2, sck half-period in clk cycles (>=1).
- ARM_CYCLES, 1, number of full sck periods with fe_rst_n held low before bit 0.
- MAX_RETRY, 3, WAIT retries (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; accepted only while busy=0.
- req  in  8  SWD request, LSB-first (bit0 Start, bit1 APnDP, bit2 RnW, bits3-4 A[3:2], bit5 parity, bit6 Stop, bit7 Park).
- wdata  in  32  write data, LSB sent first.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when the transaction ends.
- ack  out  3  captured ACK, first bit in ack[0].
- rdata  out  32  captured read data (valid at done when rnw=1 and ack=3'b001).
- rd_parity_err  out  1  read parity mismatch.
- sck  out  1  to frontend sck.
- mosi  out  1  to frontend mosi.
- miso  in  1  from frontend miso.
- fe_rst_n  out  1  to frontend rst_n.
- rnw  out  1  to frontend rnw; equals latched req[2].
- output_enable_n  out  1  to frontend; 0 while busy, else 1.

Behaviour:
- Reset values (synchronous reset, takes effect on clk edge):
  - busy=0, done=0, ack=0, rdata=0, rd_parity_err=0.
  - sck=0, mosi=0, fe_rst_n=0, rnw=0, output_enable_n=1.
  - Reset mid-frame aborts immediately and returns to IDLE. No done pulse is generated.
- States:
  - IDLE: start=1 latches req/wdata, computes wparity=^wdata, goes to ARM, busy=1.
  - ARM: fe_rst_n=0 for ARM_CYCLES sck periods. fe_rst_n rises while sck is low, then the block enters SHIFT with bit index k=0.
  - SHIFT: sck toggles every DIV clk cycles, starting low.
  - DONE: one cycle with done=1, then IDLE. busy falls in the same cycle that done is asserted.
- Bit timing:
  - mosi for bit k is stable during the entire low half preceding rising edge k; the frontend samples on the rising edge.
  - miso for bit k is sampled in the clk cycle where sck goes high->low.
  - mosi for bit k+1 is updated in that same cycle.
- mosi map:
  - k=0..1: 0.
  - k=2..9: req[k-2].
  - k=10..13: 0.
  - k=14: 0 (pad).
  - Write frames: k=15..46 carry wdata[k-15]; k=47 carries wparity.
  - Read frames: mosi=0 from k=14 onward.
- Capture:
  - k=11..13: ack[k-11] <= miso.
  - Read only: k=14..45 -> rdata[k-14]; k=46 -> parity bit; rd_parity_err = (parity != ^rdata).
- Frame end:
  - ack=3'b001: run through k=47, then DONE (48 sck periods total).
  - Any other ack: finish bit 14 (turnaround back), then DONE. No data is shifted.
- After the last falling edge, sck remains 0 and mosi=0. fe_rst_n stays 1 until the next ARM.
- start while busy=1 is ignored (no queueing).

Optional Feature:
- Macro SWD_SEQ_WAIT_RETRY_EN.
- Defined:
  - ack=3'b010 (WAIT) causes re-entry to ARM with the same req/wdata, without a done pulse, up to MAX_RETRY times.
  - A retry counter resets on each accepted start.
  - done is reported with the final ack.
- Undefined:
  - WAIT ends the transaction like any non-OK ack.
  - No retry counter exists.

Test Plan:
- Write OK: DIV=2, start with req=0xA1, wdata=0xCAFEBABE; target drives ack 1,0,0 on bits 11-13.
  - Bits 2-9 on mosi are 1,0,0,0,0,1,0,1.
  - Bits 15-46 carry wdata LSB-first; bit 47 = 0 (^0xCAFEBABE).
  - ack=3'b001; done exactly 48*4 clk cycles after fe_rst_n rises.
- Read OK: req=0xA5; target returns ack 001, data 0x12345678, parity bit 1.
  - rnw=1; rdata=0x12345678; rd_parity_err=0.
  - Same frame with parity bit 0 -> rd_parity_err=1.
- FAULT: req=0xA1; target acks 0,0,1.
  - ack=3'b100; done after 15 sck periods; mosi stays 0 after bit 9.
- WAIT retry (macro on, MAX_RETRY=3): ack 010 twice, then 001.
  - Three ARM pulses on fe_rst_n, a single done, ack=3'b001.
  - Macro off: one frame, ack=3'b010.
- Reset mid-frame: assert rst at k=20.
  - Next clk: busy=0, sck=0, output_enable_n=1, fe_rst_n=0, no done pulse.
  - A subsequent start produces a complete, correct frame.
- Start while busy: pulse start at k=5 with req=0x8D.
  - Ignored; the frame continues with req=0xA1, and exactly one done pulse occurs.

Source files
------------

// File: rtl/swd_frame_sequencer.sv
// ---------------------------------------------------------------------------
// swd_frame_sequencer
//
// Host-side SWD frame sequencer. It drives the sck/mosi/rst_n/rnw/
// output_enable_n inputs of swd_frontend_top. Each accepted start pulse
// produces one SWD transaction:
//   ARM   : fe_rst_n held low for ARM_CYCLES full sck periods.
//   SHIFT : a 48-bit frame at a sck half-period of DIV clk cycles.
//   DONE  : a one-cycle done pulse with the captured results.
//
// Configuration macro:
//   SWD_SEQ_WAIT_RETRY_EN - when defined, a WAIT ack (3'b010) re-arms and
//                           repeats the same transaction up to MAX_RETRY
//                           times before reporting done.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             one-cycle request, accepted only while busy=0
//   req[7:0]          SWD request byte, sent LSB first
//   wdata[31:0]       write data, sent LSB first
//   busy, done        transaction in progress / one-cycle completion pulse
//   ack[2:0]          captured ACK, first received bit in ack[0]
//   rdata[31:0]       captured read data
//   rd_parity_err     read parity mismatch
//   sck, mosi, miso   serial link to the frontend
//   fe_rst_n          frontend reset (low during ARM)
//   rnw               latched req[2]
//   output_enable_n   0 while busy, else 1
// ---------------------------------------------------------------------------
module swd_frame_sequencer #(
  parameter int unsigned DIV        = 2,
  parameter int unsigned ARM_CYCLES = 1,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  req,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [2:0]  ack,
  output logic [31:0] rdata,
  output logic        rd_parity_err,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        fe_rst_n,
  output logic        rnw,
  output logic        output_enable_n
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);

  localparam logic [5:0] K_TURN  = 6'd14;  // first bit after the ACK
  localparam logic [5:0] K_RLAST = 6'd45;  // last read data bit
  localparam logic [5:0] K_RPAR  = 6'd46;  // read parity bit
  localparam logic [5:0] K_LAST  = 6'd47;  // last bit of a full frame
  localparam logic [2:0] ACK_OK   = 3'b001;
  localparam logic [2:0] ACK_WAIT = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   div_cnt;
  logic [AW-1:0]   arm_cnt;
  logic [5:0]      bit_k;
  logic [7:0]      req_l;
  logic [31:0]     wdata_l;
  logic            wparity;
  logic            tick;
  logic            fall;
  logic            retry_ok;

  // mosi value for bit k of the frame being sent.
  function automatic logic frame_bit(input logic [5:0]  k,
                                     input logic [7:0]  r,
                                     input logic [31:0] w,
                                     input logic        wp);
    logic b;
    b = 1'b0;
    if (k >= 6'd2 && k <= 6'd9) begin
      b = r[k[2:0] - 3'd2];
    end else if (!r[2] && k >= 6'd15 && k <= 6'd46) begin
      b = w[k[4:0] - 5'd15];
    end else if (!r[2] && k == K_LAST) begin
      b = wp;
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

  // tick marks the last clk cycle of an sck half-period; fall is a high->low edge.
  assign tick = (div_cnt == DIV_LAST);
  assign fall = tick & sck;
  assign rnw  = req_l[2];

`ifdef SWD_SEQ_WAIT_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;

  assign retry_ok = (ack == ACK_WAIT) && (retry_cnt < RW'(MAX_RETRY));

  // Retry counter: cleared per accepted start, bumped on every re-arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      retry_cnt <= '0;
    end else if (state == S_SHIFT && state_nxt == S_ARM) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; frame end is decided on sck falling edges.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ARM;
        else       state_nxt = S_IDLE;
      end
      S_ARM: begin
        if (fall && arm_cnt == ARM_LAST) state_nxt = S_SHIFT;
        else                             state_nxt = S_ARM;
      end
      S_SHIFT: begin
        if (fall && bit_k == K_LAST) begin
          state_nxt = S_DONE;
        end else if (fall && bit_k == K_TURN && ack != ACK_OK) begin
          state_nxt = retry_ok ? S_ARM : S_DONE;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded status outputs; busy drops in the cycle done is high.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_ARM, S_SHIFT: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
    output_enable_n = ~busy;
  end

  // Datapath: sck divider, bit counter, mosi serialiser and miso capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt       <= '0;
      arm_cnt       <= '0;
      bit_k         <= 6'd0;
      req_l         <= 8'd0;
      wdata_l       <= 32'd0;
      wparity       <= 1'b0;
      ack           <= 3'd0;
      rdata         <= 32'd0;
      rd_parity_err <= 1'b0;
      sck           <= 1'b0;
      mosi          <= 1'b0;
      fe_rst_n      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            req_l         <= req;
            wdata_l       <= wdata;
            wparity       <= ^wdata;
            ack           <= 3'd0;
            rdata         <= 32'd0;
            rd_parity_err <= 1'b0;
            div_cnt       <= '0;
            arm_cnt       <= '0;
            sck           <= 1'b0;
            mosi          <= 1'b0;
            fe_rst_n      <= 1'b0;
          end
        end
        S_ARM: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) sck <= ~sck;
          if (fall) begin
            if (arm_cnt == ARM_LAST) begin
              // Release the frontend while sck is low; bit 0 follows.
              fe_rst_n <= 1'b1;
              bit_k    <= 6'd0;
              mosi     <= frame_bit(6'd0, req_l, wdata_l, wparity);
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end
        end
        S_SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) sck <= ~sck;
          if (fall) begin
            case (bit_k)
              6'd11: ack[0] <= miso;
              6'd12: ack[1] <= miso;
              6'd13: ack[2] <= miso;
              K_RPAR: begin
                if (req_l[2]) rd_parity_err <= miso ^ (^rdata);
              end
              default: begin
                // Read data shifts in LSB first, only after an OK ack.
                if (req_l[2] && ack == ACK_OK && bit_k >= K_TURN && bit_k <= K_RLAST) begin
                  rdata <= {miso, rdata[31:1]};
                end
              end
            endcase
            bit_k <= bit_k + 6'd1;
            if (state_nxt == S_SHIFT) begin
              mosi <= frame_bit(bit_k + 6'd1, req_l, wdata_l, wparity);
            end else begin
              mosi <= 1'b0;
            end
            if (state_nxt == S_ARM) begin
              fe_rst_n <= 1'b0;
              arm_cnt  <= '0;
            end
          end
        end
        default: begin
          sck  <= 1'b0;
          mosi <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swd_frame_sequencer.sv
module tb_swd_frame_sequencer;

  localparam int DIV        = 2;
  localparam int ARM_CYCLES = 1;
  localparam int MAX_RETRY  = 3;
`ifdef SWD_SEQ_WAIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  req;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        rd_parity_err;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        fe_rst_n;
  logic        rnw;
  logic        output_enable_n;

  always #5 clk = ~clk;

  swd_frame_sequencer #(
    .DIV(DIV), .ARM_CYCLES(ARM_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .req(req), .wdata(wdata),
    .busy(busy), .done(done), .ack(ack), .rdata(rdata),
    .rd_parity_err(rd_parity_err), .sck(sck), .mosi(mosi), .miso(miso),
    .fe_rst_n(fe_rst_n), .rnw(rnw), .output_enable_n(output_enable_n)
  );

  int total = 0;
  int bad   = 0;

  // Target behaviour: miso bit per frame bit, one pattern per ARM attempt.
  logic [47:0] pat_q [4];

  // Observations from the last frame.
  logic [47:0] mosi_seen;
  int          nbits, done_off, arm_rises, dones, glitches, idle_bad;
  bit          aborted;
  logic [2:0]  ack_d;
  logic [31:0] rdata_d;
  logic        perr_d, busy_d, oe_d, fe_d, rnw_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected mosi content of a frame from the request/data rules.
  function automatic logic [47:0] exp_mosi_f(input logic [7:0] r, input logic [31:0] w, input bit ok);
    logic [47:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[2+i] = r[i];
    if (ok && !r[2]) begin
      for (int i = 0; i < 32; i++) m[15+i] = w[i];
      m[47] = ^w;
    end
    return m;
  endfunction

  // Target reply: ack on bits 11..13, read data on 14..45, parity on 46.
  function automatic logic [47:0] mk_pat(input logic [2:0] a, input logic [31:0] d,
                                         input logic p, input logic [47:0] noise);
    logic [47:0] m;
    m = noise;
    for (int i = 0; i < 3; i++)  m[11+i] = a[i];
    for (int i = 0; i < 32; i++) m[14+i] = d[i];
    m[46] = p;
    return m;
  endfunction

  // Launch one transaction and follow the link bit by bit until done.
  task automatic run_frame(input logic [7:0] r, input logic [31:0] w,
                           input int abort_at, input int poke_at);
    logic psck, pfe, pmosi;
    int   k, since, post, att;
    bit   poke_clr;
    mosi_seen = '0; nbits = 0; done_off = -1; arm_rises = 0; dones = 0;
    glitches = 0; idle_bad = 0; aborted = 1'b0;
    k = 0; since = 0; post = -1; poke_clr = 1'b0;
    @(negedge clk);
    start = 1'b1; req = r; wdata = w;
    @(negedge clk);
    start = 1'b0; req = 8'($urandom); wdata = $urandom;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("rnw_latched", {63'd0, rnw}, {63'd0, r[2]});
    psck = sck; pfe = fe_rst_n; pmosi = mosi;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      since++;
      if (poke_clr) begin
        start = 1'b0; poke_clr = 1'b0;
      end
      if (fe_rst_n && !pfe) begin
        arm_rises++; k = 0; since = 0;
      end
      att = (arm_rises > 4) ? 3 : ((arm_rises < 1) ? 0 : arm_rises - 1);
      if (fe_rst_n && pfe && !sck && !psck && mosi !== pmosi) glitches++;
      if (fe_rst_n && sck && !psck) begin
        if (k < 48) begin
          mosi_seen[k] = mosi;
          miso = pat_q[att][k];
        end
        if (k == poke_at) begin
          start = 1'b1; req = 8'h8D; poke_clr = 1'b1;
        end
        if (k == abort_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("abort_busy", {63'd0, busy}, 64'd0);
          chk("abort_sck", {63'd0, sck}, 64'd0);
          chk("abort_oe_n", {63'd0, output_enable_n}, 64'd1);
          chk("abort_fe_rst_n", {63'd0, fe_rst_n}, 64'd0);
          for (int j = 0; j < 100; j++) begin
            if (done) dones++;
            @(negedge clk);
          end
          chk("abort_no_done", 64'(dones), 64'd0);
          aborted = 1'b1;
          miso = 1'b0;
          return;
        end
      end
      if (pfe && psck && !sck) begin
        k++; nbits = k;
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          done_off = since; ack_d = ack; rdata_d = rdata; perr_d = rd_parity_err;
          busy_d = busy; oe_d = output_enable_n; fe_d = fe_rst_n; rnw_d = rnw;
        end
        if (post < 0) post = 0;
      end
      if (post >= 0) begin
        if (sck || mosi) idle_bad++;
        post++;
        if (post > 10) break;
      end
      psck = sck; pfe = fe_rst_n; pmosi = mosi;
    end
    miso = 1'b0;
    chk("done_within_budget", {63'd0, (dones > 0)}, 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] r, input logic [31:0] w,
                              input logic [2:0] a, input logic [31:0] d, input logic p,
                              input int arms);
    bit          ok;
    int          nb;
    logic [47:0] mask, em;
    ok   = (a == 3'b001);
    nb   = ok ? 48 : 15;
    mask = (nb == 48) ? {48{1'b1}} : ((48'd1 << nb) - 48'd1);
    em   = exp_mosi_f(r, w, ok);
    chk({tag, "_ack"}, 64'(ack_d), 64'(a));
    chk({tag, "_dones"}, 64'(dones), 64'd1);
    chk({tag, "_arms"}, 64'(arm_rises), 64'(arms));
    chk({tag, "_nbits"}, 64'(nbits), 64'(nb));
    chk({tag, "_done_off"}, 64'(done_off), 64'(nb * 2 * DIV));
    chk({tag, "_mosi"}, 64'(mosi_seen & mask), 64'(em & mask));
    chk({tag, "_mosi_stable"}, 64'(glitches), 64'd0);
    chk({tag, "_idle_link"}, 64'(idle_bad), 64'd0);
    chk({tag, "_busy_at_done"}, {63'd0, busy_d}, 64'd0);
    chk({tag, "_oe_at_done"}, {63'd0, oe_d}, 64'd1);
    chk({tag, "_fe_at_done"}, {63'd0, fe_d}, 64'd1);
    chk({tag, "_rnw_at_done"}, {63'd0, rnw_d}, {63'd0, r[2]});
    if (r[2] && ok) begin
      chk({tag, "_rdata"}, 64'(rdata_d), 64'(d));
      chk({tag, "_perr"}, {63'd0, perr_d}, {63'd0, (p != ^d)});
    end
  endtask

  task automatic do_txn(input string tag, input logic [7:0] r, input logic [31:0] w,
                        input logic [2:0] a, input logic [31:0] d, input logic p,
                        input int abort_at, input int poke_at);
    logic [47:0] pt;
    int          arms;
    pt = mk_pat(a, d, p, {16'($urandom), $urandom});
    for (int i = 0; i < 4; i++) pat_q[i] = pt;
    run_frame(r, w, abort_at, poke_at);
    if (!aborted) begin
      arms = (RETRY_EN && a == 3'b010) ? MAX_RETRY + 1 : 1;
      check_result(tag, r, w, a, d, p, arms);
    end
  endtask

  initial begin
    logic [7:0]  rr;
    logic [31:0] ww, dd;
    logic [2:0]  aa;
    int          sel;
    rst = 1'b1; start = 1'b0; req = 8'd0; wdata = 32'd0; miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_perr", {63'd0, rd_parity_err}, 64'd0);
    chk("rst_sck_mosi", {62'd0, sck, mosi}, 64'd0);
    chk("rst_fe_rnw", {62'd0, fe_rst_n, rnw}, 64'd0);
    chk("rst_oe_n", {63'd0, output_enable_n}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    do_txn("wr_ok", 8'hA1, 32'hCAFEBABE, 3'b001, $urandom, 1'b0, -1, -1);
    do_txn("rd_ok", 8'hA5, $urandom, 3'b001, 32'h12345678, 1'b1, -1, -1);
    do_txn("rd_perr", 8'hA5, $urandom, 3'b001, 32'h12345678, 1'b0, -1, -1);
    do_txn("fault", 8'hA1, 32'h0F0F_1234, 3'b100, $urandom, 1'b1, -1, -1);

    // WAIT twice, then OK.
    ww = $urandom;
    pat_q[0] = mk_pat(3'b010, $urandom, 1'b0, {16'($urandom), $urandom});
    pat_q[1] = mk_pat(3'b010, $urandom, 1'b1, {16'($urandom), $urandom});
    pat_q[2] = mk_pat(3'b001, $urandom, 1'b0, {16'($urandom), $urandom});
    pat_q[3] = pat_q[2];
    run_frame(8'hA1, ww, -1, -1);
`ifdef SWD_SEQ_WAIT_RETRY_EN
    check_result("retry", 8'hA1, ww, 3'b001, 32'd0, 1'b0, 3);
`else
    check_result("retry", 8'hA1, ww, 3'b010, 32'd0, 1'b0, 1);
`endif

    do_txn("abort", 8'hA1, $urandom, 3'b001, $urandom, 1'b0, 20, -1);
    do_txn("post_abort", 8'hA5, $urandom, 3'b001, 32'h89AB_CDEF, 1'b0, -1, -1);
    do_txn("start_busy", 8'hA1, $urandom, 3'b001, $urandom, 1'b0, -1, 5);

    for (int n = 0; n < 12; n++) begin
      rr  = 8'($urandom);
      ww  = $urandom;
      dd  = $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0, 1:    aa = 3'b001;
        2:       aa = 3'b010;
        3:       aa = 3'b100;
        default: aa = 3'($urandom);
      endcase
      do_txn("rand", rr, ww, aa, dd, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
